// File: rtl/axi_slave_wr_packer.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_wr_packer
// Brief    : AXI write slave that packs narrow beats into wide native words.
// Revision : 1.0 - initial release
// ============================================================================
module axi_slave_wr_packer #(
  parameter int          AXI_W       = 32,
  parameter int          MEM_W       = 256,
  parameter int          MEM_ADDR_W  = 28,
  parameter logic [31:0] OFFSET_ADDR = 32'h0000_0000,
  parameter logic [31:0] WINDOW      = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            SLAVE_WR_ADDR_ID,
  input  logic [31:0]           SLAVE_WR_ADDR,
  input  logic [7:0]            SLAVE_WR_ADDR_LEN,
  input  logic [1:0]            SLAVE_WR_ADDR_BURST,
  input  logic                  SLAVE_WR_ADDR_VALID,
  output logic                  SLAVE_WR_ADDR_READY,
  input  logic [AXI_W-1:0]      SLAVE_WR_DATA,
  input  logic [AXI_W/8-1:0]    SLAVE_WR_STRB,
  input  logic                  SLAVE_WR_DATA_LAST,
  input  logic                  SLAVE_WR_DATA_VALID,
  output logic                  SLAVE_WR_DATA_READY,
  output logic [3:0]            SLAVE_WR_BACK_ID,
  output logic [1:0]            SLAVE_WR_BACK_RESP,
  output logic                  SLAVE_WR_BACK_VALID,
  input  logic                  SLAVE_WR_BACK_READY,
  output logic [MEM_ADDR_W-1:0] MEM_WR_ADDR,
  output logic [7:0]            MEM_WR_LEN,
  output logic [3:0]            MEM_WR_ID,
  output logic                  MEM_WR_ADDR_VALID,
  input  logic                  MEM_WR_ADDR_READY,
  output logic [MEM_W-1:0]      MEM_WR_DATA,
  output logic [MEM_W/8-1:0]    MEM_WR_STRB,
  output logic                  MEM_WR_DATA_LAST,
  output logic                  MEM_WR_DATA_VALID,
  input  logic                  MEM_WR_DATA_READY
);

  localparam int c_bytes  = AXI_W / 8;
  localparam int c_mbytes = MEM_W / 8;
  localparam int c_ratio  = MEM_W / AXI_W;
  localparam int c_lb     = $clog2(c_bytes);
  localparam int c_lmb    = $clog2(c_mbytes);
  localparam int c_lr     = $clog2(c_ratio);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MADDR = 3'd1,
    S_PACK  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_aw_ready;
  logic [3:0]            r_id;
  logic [1:0]            r_resp;
  logic [MEM_ADDR_W-1:0] r_maddr;
  logic [7:0]            r_mlen;
  logic [c_lr-1:0]       r_lane;
  logic                  r_wlast_done;
  logic [MEM_W-1:0]      r_pack_data, r_out_data;
  logic [c_mbytes-1:0]   r_pack_strb, r_out_strb;
  logic                  r_out_valid, r_out_last;

  logic                  w_aw_hs, w_incr, w_inwin, w_pack, w_wready, w_whs, w_emit;
  logic [31:0]           w_rel_raw, w_rel;
  logic [63:0]           w_rel64;
  logic [32:0]           w_span;
  logic [c_lr-1:0]       w_lane0;
  logic [15:0]           w_lsum, w_lsum_sh;
  logic [MEM_W-1:0]      w_word_data;
  logic [c_mbytes-1:0]   w_word_strb;
  logic                  w_unused;

  // Window check on the lane-aligned relative address; 33-bit math keeps the end-of-window case exact.
  assign w_aw_hs   = SLAVE_WR_ADDR_VALID & r_aw_ready;
  assign w_rel_raw = SLAVE_WR_ADDR - OFFSET_ADDR;
  assign w_rel     = w_rel_raw & ~((32'd1 << c_lb) - 32'd1);
  assign w_rel64   = {32'd0, w_rel};
  assign w_span    = ({25'd0, SLAVE_WR_ADDR_LEN} + 33'd1) << c_lb;
  assign w_inwin   = ({1'b0, w_rel} < {1'b0, WINDOW}) &&
                     (({1'b0, w_rel} + w_span) <= {1'b0, WINDOW});
  assign w_incr    = (SLAVE_WR_ADDR_BURST == 2'b01);
  assign w_lane0   = w_rel[c_lmb-1:c_lb];
  assign w_lsum    = {8'd0, SLAVE_WR_ADDR_LEN} + {{(16-c_lr){1'b0}}, w_lane0};
  assign w_lsum_sh = w_lsum >> c_lr;
  assign w_unused  = ^{w_rel64, w_lsum_sh};

  assign w_pack   = (r_state == S_PACK);
  assign w_wready = (w_pack & ~r_wlast_done & (~r_out_valid | MEM_WR_DATA_READY)) |
                    (r_state == S_DRAIN);
  assign w_whs    = SLAVE_WR_DATA_VALID & w_wready;
  assign w_emit   = w_whs & w_pack & ((&r_lane) | SLAVE_WR_DATA_LAST);

  always_comb begin
    w_word_data = r_pack_data;
    w_word_strb = r_pack_strb;
    w_word_data[r_lane*AXI_W +: AXI_W]   = SLAVE_WR_DATA;
    w_word_strb[r_lane*c_bytes +: c_bytes] = SLAVE_WR_STRB;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_aw_hs) w_state_nxt = (w_incr & w_inwin) ? S_MADDR : S_DRAIN;
      S_MADDR: if (MEM_WR_ADDR_READY) w_state_nxt = S_PACK;
      S_PACK:  if (r_out_valid & MEM_WR_DATA_READY & r_out_last) w_state_nxt = S_RESP;
      S_DRAIN: if (SLAVE_WR_DATA_VALID & SLAVE_WR_DATA_LAST) w_state_nxt = S_RESP;
      S_RESP:  if (SLAVE_WR_BACK_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_ready   <= 1'b0;
      r_id         <= '0;
      r_resp       <= '0;
      r_maddr      <= '0;
      r_mlen       <= '0;
      r_lane       <= '0;
      r_wlast_done <= 1'b0;
      r_pack_data  <= '0;
      r_pack_strb  <= '0;
      r_out_data   <= '0;
      r_out_strb   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      r_aw_ready <= (w_state_nxt == S_IDLE);
      if (w_aw_hs) begin
        r_id         <= SLAVE_WR_ADDR_ID;
        r_resp       <= !w_incr ? 2'd2 : (!w_inwin ? 2'd3 : 2'd0);
        r_maddr      <= w_rel64[c_lmb +: MEM_ADDR_W];
        r_mlen       <= w_lsum_sh[7:0];
        r_lane       <= w_lane0;
        r_wlast_done <= 1'b0;
        r_pack_data  <= '0;
        r_pack_strb  <= '0;
      end
      if (w_whs & w_pack) begin
        r_lane <= r_lane + 1'b1;
        if (SLAVE_WR_DATA_LAST) r_wlast_done <= 1'b1;
        if (w_emit) begin
          r_out_data  <= w_word_data;
          r_out_strb  <= w_word_strb;
          r_out_last  <= SLAVE_WR_DATA_LAST;
          r_pack_data <= '0;
          r_pack_strb <= '0;
        end else begin
          r_pack_data <= w_word_data;
          r_pack_strb <= w_word_strb;
        end
      end
      // W is only accepted when the output slot frees this cycle, so an emit never overwrites.
      if (w_emit)                 r_out_valid <= 1'b1;
      else if (MEM_WR_DATA_READY) r_out_valid <= 1'b0;
    end
  end

  assign SLAVE_WR_ADDR_READY = r_aw_ready;
  assign SLAVE_WR_DATA_READY = w_wready;
  assign SLAVE_WR_BACK_ID    = r_id;
  assign SLAVE_WR_BACK_RESP  = r_resp;
  assign SLAVE_WR_BACK_VALID = (r_state == S_RESP);
  assign MEM_WR_ADDR         = r_maddr;
  assign MEM_WR_LEN          = r_mlen;
  assign MEM_WR_ID           = r_id;
  assign MEM_WR_ADDR_VALID   = (r_state == S_MADDR);
  assign MEM_WR_DATA         = r_out_data;
  assign MEM_WR_STRB         = r_out_strb;
  assign MEM_WR_DATA_LAST    = r_out_last;
  assign MEM_WR_DATA_VALID   = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_wr_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_wr_packer
// Brief    : Directed vector bench for axi_slave_wr_packer (OFFSET 0x8000_0000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_wr_packer;

  localparam logic [31:0] c_off = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   aw_id = '0;
  logic [31:0]  aw_addr = '0;
  logic [7:0]   aw_len = '0;
  logic [1:0]   aw_burst = '0;
  logic         aw_valid = 1'b0, aw_ready;
  logic [31:0]  w_data = '0;
  logic [3:0]   w_strb = '0;
  logic         w_last = 1'b0, w_valid = 1'b0, w_ready;
  logic [3:0]   b_id;
  logic [1:0]   b_resp;
  logic         b_valid, b_ready = 1'b0;
  logic [27:0]  m_addr;
  logic [7:0]   m_len;
  logic [3:0]   m_id;
  logic         m_avalid, m_aready = 1'b0;
  logic [255:0] m_data;
  logic [31:0]  m_strb;
  logic         m_last, m_dvalid, m_dready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_slave_wr_packer #(
    .AXI_W(32), .MEM_W(256), .MEM_ADDR_W(28),
    .OFFSET_ADDR(c_off), .WINDOW(32'h1000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
    .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp), .SLAVE_WR_BACK_VALID(b_valid),
    .SLAVE_WR_BACK_READY(b_ready),
    .MEM_WR_ADDR(m_addr), .MEM_WR_LEN(m_len), .MEM_WR_ID(m_id),
    .MEM_WR_ADDR_VALID(m_avalid), .MEM_WR_ADDR_READY(m_aready),
    .MEM_WR_DATA(m_data), .MEM_WR_STRB(m_strb), .MEM_WR_DATA_LAST(m_last),
    .MEM_WR_DATA_VALID(m_dvalid), .MEM_WR_DATA_READY(m_dready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    int          nbeats;
    logic [3:0]  strb;
    int          stall;
    logic [27:0] e_maddr;
    logic [7:0]  e_mlen;
    int          e_nwords;
    logic [31:0] e_strb0;
    logic [31:0] e_strbl;
    logic [1:0]  e_resp;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int vi, input int k);
    return {8'(vi), 8'hA5, 16'(k)};
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int           beat = 0;
    int           nmaddr = 0;
    int           nw = 0;
    int           lane0;
    bit           aw_done = 0;
    bit           done = 0;
    bit           hold_bad = 0;
    logic [31:0]  rel;
    logic [27:0]  gaddr = '0;
    logic [7:0]   glen = '0;
    logic [3:0]   gid = '0, gbid = '0;
    logic [1:0]   gresp = '0;
    logic [255:0] gdata[4];
    logic [31:0]  gstrb[4];
    logic         glast[4];
    logic [255:0] edata[4];
    logic [255:0] emask[4];
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      aw_valid = !aw_done; aw_addr = v.addr; aw_len = v.len; aw_burst = v.burst; aw_id = v.id;
      w_valid  = (beat < v.nbeats);
      w_data   = pat(vi, beat);
      w_strb   = v.strb;
      w_last   = (beat == v.nbeats - 1);
      m_aready = 1'b1;
      m_dready = (c >= v.stall);
      b_ready  = 1'b1;
      #1;
      if (aw_valid && aw_ready) aw_done = 1;
      if (m_avalid && m_aready) begin
        nmaddr++; gaddr = m_addr; glen = m_len; gid = m_id;
      end
      if (m_dvalid && !m_dready && w_ready) hold_bad = 1;
      if (w_valid && w_ready) beat++;
      if (m_dvalid && m_dready) begin
        if (nw < 4) begin gdata[nw] = m_data; gstrb[nw] = m_strb; glast[nw] = m_last; end
        nw++;
      end
      if (b_valid && b_ready) begin gresp = b_resp; gbid = b_id; done = 1; end
    end
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; m_dready = 1'b1; b_ready = 1'b0;

    chk($sformatf("v%0d.finished", vi), done, 1);
    chk($sformatf("v%0d.wbeats", vi), beat, v.nbeats);
    chk($sformatf("v%0d.naddr", vi), nmaddr, (v.e_nwords > 0) ? 1 : 0);
    chk($sformatf("v%0d.nwords", vi), nw, v.e_nwords);
    chk($sformatf("v%0d.wready_hold", vi), hold_bad, 0);
    chk($sformatf("v%0d.bresp", vi), gresp, v.e_resp);
    chk($sformatf("v%0d.bid", vi), gbid, v.id);
    if (v.e_nwords > 0 && nw == v.e_nwords) begin
      chk($sformatf("v%0d.maddr", vi), gaddr, v.e_maddr);
      chk($sformatf("v%0d.mlen", vi), glen, v.e_mlen);
      chk($sformatf("v%0d.mid", vi), gid, v.id);
      chk($sformatf("v%0d.strb0", vi), gstrb[0], v.e_strb0);
      chk($sformatf("v%0d.strblast", vi), gstrb[nw-1], v.e_strbl);
      rel   = v.addr - c_off;
      lane0 = int'((rel >> 2) & 32'h7);
      for (int w = 0; w < 4; w++) begin edata[w] = '0; emask[w] = '0; end
      for (int k = 0; k < v.nbeats; k++) begin
        edata[(lane0 + k) / 8][((lane0 + k) % 8) * 32 +: 32] = pat(vi, k);
        emask[(lane0 + k) / 8][((lane0 + k) % 8) * 32 +: 32] = '1;
      end
      for (int w = 0; w < nw; w++) begin
        chk($sformatf("v%0d.data%0d", vi, w), gdata[w] & emask[w], edata[w]);
        chk($sformatf("v%0d.last%0d", vi, w), glast[w], (w == nw - 1) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    int sent;
    bit aw_done;
    //        addr          len    burst  id   nb  strb stall maddr        mlen   nw strb0          strb_last      resp
    vt[0]  = '{32'h8000_0020, 8'd7,  2'b01, 4'd5, 8,  4'hF, 0,  28'h1,       8'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0};
    vt[1]  = '{32'h8000_000C, 8'd7,  2'b01, 4'd3, 8,  4'hF, 0,  28'h0,       8'd1, 2, 32'hFFFF_F000, 32'h0000_0FFF, 2'd0};
    vt[2]  = '{32'h9000_0000, 8'd3,  2'b01, 4'd7, 4,  4'hF, 0,  28'h0,       8'd0, 0, 32'h0,         32'h0,         2'd3};
    vt[3]  = '{32'h8000_0100, 8'd1,  2'b10, 4'd9, 2,  4'hF, 0,  28'h0,       8'd0, 0, 32'h0,         32'h0,         2'd2};
    vt[4]  = '{32'h8000_0020, 8'd7,  2'b01, 4'd5, 8,  4'hF, 10, 28'h1,       8'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0};
    vt[5]  = '{32'h8FFF_FFF0, 8'd3,  2'b01, 4'd1, 4,  4'hF, 0,  28'h07F_FFFF, 8'd0, 1, 32'hFFFF_0000, 32'hFFFF_0000, 2'd0};
    vt[6]  = '{32'h8FFF_FFF0, 8'd4,  2'b01, 4'd2, 5,  4'hF, 0,  28'h0,       8'd0, 0, 32'h0,         32'h0,         2'd3};
    vt[7]  = '{32'h9000_0000, 8'd0,  2'b00, 4'd6, 1,  4'hF, 0,  28'h0,       8'd0, 0, 32'h0,         32'h0,         2'd2};
    vt[8]  = '{32'h8000_0044, 8'd15, 2'b01, 4'd8, 16, 4'hF, 10, 28'h2,       8'd2, 3, 32'hFFFF_FFF0, 32'h0000_000F, 2'd0};
    vt[9]  = '{32'h8000_0006, 8'd0,  2'b01, 4'hA, 1,  4'hA, 0,  28'h0,       8'd0, 1, 32'h0000_00A0, 32'h0000_00A0, 2'd0};
    vt[10] = '{32'h8000_0000, 8'd15, 2'b01, 4'hB, 3,  4'hF, 0,  28'h0,       8'd1, 1, 32'h0000_0FFF, 32'h0000_0FFF, 2'd0};
    vt[11] = '{32'h7FFF_FFFC, 8'd0,  2'b01, 4'hC, 1,  4'hF, 0,  28'h0,       8'd0, 0, 32'h0,         32'h0,         2'd3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.aw_ready", aw_ready, 0);
    chk("rst.valids", {w_ready, b_valid, m_avalid, m_dvalid}, 4'h0);
    chk("rst.payload", {m_addr, m_len, m_id, b_id, b_resp, m_strb, m_last}, '0);
    chk("rst.data", m_data, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.aw_ready_after", aw_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Mid-burst reset: 3 beats of a LEN=15 burst, then a 1-cycle reset.
    sent = 0; aw_done = 0;
    for (int c = 0; c < 50 && sent < 3; c++) begin
      @(negedge clk);
      aw_valid = !aw_done; aw_addr = c_off; aw_len = 8'd15; aw_burst = 2'b01; aw_id = 4'd4;
      w_valid = 1'b1; w_data = pat(20, sent); w_strb = 4'hF; w_last = 1'b0;
      m_aready = 1'b1; m_dready = 1'b1; b_ready = 1'b1;
      #1;
      if (aw_valid && aw_ready) aw_done = 1;
      if (w_valid && w_ready) sent++;
    end
    chk("mrst.beats_sent", sent, 3);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst.aw_ready", aw_ready, 0);
    chk("mrst.valids", {w_ready, b_valid, m_avalid, m_dvalid}, 4'h0);
    chk("mrst.payload", {m_addr, m_len, m_id, b_id, b_resp, m_strb, m_last}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst.aw_ready_after", aw_ready, 1);
    run_vec(vt[0], 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
